// File: rtl/quad_decoder_4bit.sv
// Quadrature decoder: per-phase synchronizers, stability filter, and a 4-bit
// wrapping position counter with direction, step pulse and sticky error flag.
module quad_decoder_4bit #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       quad_a,
  input  logic       quad_b,
  input  logic       clear,
  input  logic       err_clr,
  output logic [3:0] counter,
  output logic       up_down_flag,
  output logic       step,
  output logic       error,
  output logic       valid
);

  logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d, sync_b_q, sync_b_d;
  logic [SYNC_STAGES-1:0] vld_pipe_q, vld_pipe_d;
  logic [1:0] filt_q, filt_d, cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] counter_q, counter_d;
  logic       udf_q, udf_d, step_q, step_d, error_q, error_d, valid_q, valid_d;

  logic [1:0] sync_ab, delta;
  logic       pending, accept, is_up, is_dn, is_ill;

  // Gray position of {a,b}: 00->0, 10->1, 11->2, 01->3
  function automatic logic [1:0] pos(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction

  always_comb begin
    sync_a_d   = {sync_a_q[SYNC_STAGES-2:0], quad_a};
    sync_b_d   = {sync_b_q[SYNC_STAGES-2:0], quad_b};
    // Marks when the synchronizer holds real samples rather than reset zeros
    vld_pipe_d = {vld_pipe_q[SYNC_STAGES-2:0], 1'b1};
    sync_ab    = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};

    // Before a baseline exists every settled sample is a candidate
    pending = valid_q ? (sync_ab != filt_q) : vld_pipe_q[SYNC_STAGES-1];
    cnt_d   = 4'd0;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (pending) begin
      cand_d = sync_ab;
      cnt_d  = (cnt_q != 4'd0 && sync_ab == cand_q) ? cnt_q + 4'd1 : 4'd1;
      if (cnt_d == 4'(FILTER_CYCLES)) begin
        accept = 1'b1;
        cnt_d  = 4'd0;
      end
    end

    delta  = pos(sync_ab) - pos(filt_q);
    is_up  = accept && valid_q && (delta == 2'd1);
    is_dn  = accept && valid_q && (delta == 2'd3);
    is_ill = accept && valid_q && (delta == 2'd2);

    filt_d  = accept ? sync_ab : filt_q;
    valid_d = valid_q | accept;
    step_d  = is_up | is_dn;
    udf_d   = is_up ? 1'b1 : (is_dn ? 1'b0 : udf_q);

    counter_d = counter_q;
    if (clear)      counter_d = 4'd0;
    else if (is_up) counter_d = counter_q + 4'd1;
    else if (is_dn) counter_d = counter_q - 4'd1;

    error_d = error_q;
    if (is_ill)       error_d = 1'b1;
    else if (err_clr) error_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a_q   <= '0;
      sync_b_q   <= '0;
      vld_pipe_q <= '0;
      filt_q     <= 2'b00;
      cand_q     <= 2'b00;
      cnt_q      <= 4'd0;
      counter_q  <= 4'd0;
      udf_q      <= 1'b0;
      step_q     <= 1'b0;
      error_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      sync_a_q   <= sync_a_d;
      sync_b_q   <= sync_b_d;
      vld_pipe_q <= vld_pipe_d;
      filt_q     <= filt_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      counter_q  <= counter_d;
      udf_q      <= udf_d;
      step_q     <= step_d;
      error_q    <= error_d;
      valid_q    <= valid_d;
    end
  end

  assign counter      = counter_q;
  assign up_down_flag = udf_q;
  assign step         = step_q;
  assign error        = error_q;
  assign valid        = valid_q;

endmodule

// File: tb/tb_quad_decoder_4bit.sv
// Directed bench for quad_decoder_4bit with default parameters (edge-5 latency).
module tb_quad_decoder_4bit;
  logic       clk = 1'b0, reset = 1'b1;
  logic       quad_a = 1'b0, quad_b = 1'b0, clear = 1'b0, err_clr = 1'b0;
  logic [3:0] counter;
  logic       up_down_flag, step, error, valid;
  int checks = 0, failures = 0, step_seen = 0;

  quad_decoder_4bit dut (
    .clk(clk), .reset(reset), .quad_a(quad_a), .quad_b(quad_b),
    .clear(clear), .err_clr(err_clr), .counter(counter),
    .up_down_flag(up_down_flag), .step(step), .error(error), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (step === 1'b1) step_seen++;
  endtask

  // Drive a new level and check it lands exactly on the 5th edge
  task automatic move(input logic [1:0] v, input logic [3:0] old_cnt, input logic [3:0] new_cnt,
                      input logic exp_step, input logic exp_udf, input string tag);
    {quad_a, quad_b} = v;
    repeat (4) tick();
    chk({tag, "_pre_cnt"}, 32'(counter), 32'(old_cnt));
    chk({tag, "_pre_step"}, 32'(step), 32'd0);
    tick();
    chk({tag, "_cnt"}, 32'(counter), 32'(new_cnt));
    chk({tag, "_step"}, 32'(step), 32'(exp_step));
    chk({tag, "_udf"}, 32'(up_down_flag), 32'(exp_udf));
    repeat (3) tick();
    chk({tag, "_step_off"}, 32'(step), 32'd0);
  endtask

  initial begin
    logic [1:0] up_seq [4];
    up_seq = '{2'b10, 2'b11, 2'b01, 2'b00};

    #3;
    chk("rst_cnt", 32'(counter), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    tick();
    reset = 1'b0;
    step_seen = 0;
    repeat (4) tick();
    chk("base_valid_early", 32'(valid), 32'd0);
    tick();
    chk("base_valid", 32'(valid), 32'd1);
    chk("base_cnt", 32'(counter), 32'd0);
    chk("base_err", 32'(error), 32'd0);
    repeat (3) tick();
    chk("base_steps", 32'(step_seen), 32'd0);

    step_seen = 0;
    for (int i = 1; i <= 17; i++)
      move(up_seq[(i-1)%4], 4'((i-1)%16), 4'(i%16), 1'b1, 1'b1, $sformatf("up%0d", i));
    chk("up_steps", 32'(step_seen), 32'd17);
    chk("up_final", 32'(counter), 32'd1);

    // State 10, counter 1: walk down through the wrap
    move(2'b00, 4'h1, 4'h0, 1'b1, 1'b0, "dn0");
    move(2'b01, 4'h0, 4'hF, 1'b1, 1'b0, "dnF");
    move(2'b11, 4'hF, 4'hE, 1'b1, 1'b0, "dnE");
    move(2'b10, 4'hE, 4'hD, 1'b1, 1'b0, "dnD");
    move(2'b00, 4'hD, 4'hC, 1'b1, 1'b0, "dnC");

    step_seen = 0;
    {quad_a, quad_b} = 2'b10;
    repeat (2) tick();
    {quad_a, quad_b} = 2'b00;
    repeat (10) tick();
    chk("glitch_cnt", 32'(counter), 32'hC);
    chk("glitch_err", 32'(error), 32'd0);
    chk("glitch_steps", 32'(step_seen), 32'd0);

    move(2'b11, 4'hC, 4'hC, 1'b0, 1'b0, "ill");
    chk("ill_err", 32'(error), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr", 32'(error), 32'd0);
    move(2'b01, 4'hC, 4'hD, 1'b1, 1'b1, "post_ill");

    {quad_a, quad_b} = 2'b00;
    repeat (4) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_cnt", 32'(counter), 32'd0);
    chk("clr_step", 32'(step), 32'd1);
    chk("clr_udf", 32'(up_down_flag), 32'd1);

    {quad_a, quad_b} = 2'b11;
    repeat (4) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("ill_vs_errclr", 32'(error), 32'd1);
    chk("ill_vs_errclr_step", 32'(step), 32'd0);

    // Counter is nonzero going into the async reset
    move(2'b01, 4'h0, 4'h1, 1'b1, 1'b1, "pre_rst");
    {quad_a, quad_b} = 2'b00;
    repeat (2) tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_cnt", 32'(counter), 32'd0);
    chk("arst_udf", 32'(up_down_flag), 32'd0);
    chk("arst_err", 32'(error), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    tick();
    reset = 1'b0;
    step_seen = 0;
    repeat (4) tick();
    chk("rebase_valid_early", 32'(valid), 32'd0);
    tick();
    chk("rebase_valid", 32'(valid), 32'd1);
    chk("rebase_cnt", 32'(counter), 32'd0);
    repeat (3) tick();
    chk("rebase_steps", 32'(step_seen), 32'd0);
    move(2'b01, 4'h0, 4'hF, 1'b1, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/quad_decoder_4bit.md
QUAD_DECODER_4BIT -- requirements
Module: quad_decoder_4bit

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops per quadrature input (legal range 2-4).
REQ-002 Parameter FILTER_CYCLES, default 3, number of consecutive identical synchronized samples required to accept a new input level (legal range 1-15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset for all state.
REQ-005 quad_a  input  1  quadrature phase A; asynchronous to clk.
REQ-006 quad_b  input  1  quadrature phase B; asynchronous to clk.
REQ-007 clear  input  1  synchronous clear of counter.
REQ-008 err_clr  input  1  synchronous clear of error.
REQ-009 counter  output  4  position count, registered.
REQ-010 up_down_flag  output  1  direction of the last accepted step; 1 = up, 0 = down; registered.
REQ-011 step  output  1  one-cycle pulse on each accepted step.
REQ-012 error  output  1  sticky illegal-transition flag.
REQ-013 valid  output  1  high once a baseline input state has been captured.

Function
REQ-014 Each of quad_a and quad_b SHALL pass through its own SYNC_STAGES-flop synchronizer before any other use.
REQ-015 Filter: the filtered pair {a_f,b_f} SHALL update only after the synchronized pair differs from {a_f,b_f} and holds the same value for FILTER_CYCLES consecutive edges; any change of the candidate value restarts the stability count.
REQ-016 Latency: for a clean level change, the filtered update, and any resulting counter/step change, SHALL occur on rising edge SYNC_STAGES+FILTER_CYCLES, counting the first edge that samples the new level as edge 1 (edge 5 with defaults).
REQ-017 Baseline: while valid=0, the first accepted filtered value SHALL load {a_f,b_f} and set valid=1, with no step, no count change and no error.
REQ-018 Up sequence {a,b}: 00->10->11->01->00; each accepted transition in this order SHALL increment counter by 1, set up_down_flag=1 and pulse step.
REQ-019 Down sequence {a,b}: 00->01->11->10->00; each accepted transition in this order SHALL decrement counter by 1, set up_down_flag=0 and pulse step.
REQ-020 Wrap-around: up from 4'hF SHALL give 4'h0; down from 4'h0 SHALL give 4'hF; no saturation.
REQ-021 Illegal transition (both bits change in one accepted update, e.g. 00->11) SHALL set error=1, load the new value as baseline, and leave counter, up_down_flag and step unchanged (step=0).
REQ-022 step SHALL be high for exactly one cycle per accepted legal transition and low otherwise.
REQ-023 clear=1 SHALL set counter to 0 on that edge; if a legal step is accepted on the same edge, clear wins for counter while step and up_down_flag still update.
REQ-024 err_clr=1 SHALL set error=0 on that edge unless a new illegal transition is accepted on the same edge, in which case error SHALL be 1.
REQ-025 clear and err_clr SHALL NOT affect valid, the synchronizers or the filter.

Reset
REQ-026 reset=1 SHALL immediately, without waiting for clk, force counter=4'h0, up_down_flag=0, step=0, error=0, valid=0, all synchronizer flops, the filtered pair and the stability count to 0.
REQ-027 Reset asserted mid-sequence SHALL discard any partially filtered level; after release a new baseline SHALL be captured per REQ-017 before any counting.

Verification
REQ-028 Reset with inputs at 00, then release -> valid=1 after 5 edges, counter=0, step never pulses, error=0.
REQ-029 From baseline 00, drive 17 up transitions, each held for 8 cycles -> counter steps 1..15 then wraps to 0 and reaches 1, up_down_flag=1, 17 step pulses.
REQ-030 From counter=0, drive 2 down transitions -> counter 4'hF then 4'hE, up_down_flag=0, each counter change on edge 5 after the input change.
REQ-031 Glitch: while in state 00, assert quad_a for 2 cycles only (FILTER_CYCLES=3) -> no step, counter unchanged, error=0.
REQ-032 Jump 00->11 held stable -> error=1, counter unchanged, step=0; then pulse err_clr -> error=0; then legal 11->01 -> counter +1.
REQ-033 Assert clear on the same edge a legal up step is accepted -> counter=0, step=1, up_down_flag=1; assert reset asynchronously mid-filter -> all outputs 0 before the next clk edge.
